// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU front-end: data width,
// ALU opcode encodings and sequencer state codes.
package alu_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_OR  = 2'd3
   } alu_op_e;

   localparam logic [2:0] S_A    = 3'd0;
   localparam logic [2:0] S_B    = 3'd1;
   localparam logic [2:0] S_OP   = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   // Byte-input stages are the only states that take a byte.
   function automatic logic takes_byte(input logic [2:0] st);
      return (st == S_A) || (st == S_B) || (st == S_OP);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Byte-in / result-out handshake bundle for alu_op_sequencer.
// master = stream producer/consumer, slave = sequencer.
interface alu_op_sequencer_if;
   import alu_pkg::*;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] res_data;
   logic              res_valid;
   logic              res_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  res_data,
      input  res_valid,
      output res_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output res_data,
      output res_valid,
      input  res_ready
   );

endinterface

// File: rtl/alu_op_sequencer.sv
// Serial A/B/opcode loader and result holder in front of alu_8bits.
// Define ALU_SEQ_ACCUM_EN to chain a result back into operand A.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   alu_op_sequencer_if.slave bus,
   input  logic              abort,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_s,
   input  logic [DATA_W-1:0] alu_result,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE =
      {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [1:0]        s_q, s_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              vld_q, vld_d;
   logic [CNT_W-1:0]  ops_q, ops_d;

   logic in_rdy;
   logic xfer;
   logic accept;
   logic exec_done;

`ifdef ALU_SEQ_ACCUM_EN
   logic chain_q, chain_d;
   logic unused_op_bits;
   assign unused_op_bits = ^bus.in_data[6:2];
`else
   logic unused_op_bits;
   assign unused_op_bits = ^bus.in_data[7:2];
`endif

   assign in_rdy    = takes_byte(state_q);
   assign xfer      = bus.in_valid & in_rdy;
   assign accept    = (state_q == S_OUT) & bus.res_ready;
   assign exec_done = (cnt_q + 4'd1) == EXEC_LAST;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      res_d   = res_q;
      vld_d   = vld_q;
      ops_d   = ops_q;
`ifdef ALU_SEQ_ACCUM_EN
      chain_d = chain_q;
`endif

      unique case (1'b1)
         state_q == S_A: begin
            if (xfer) begin
               a_d     = bus.in_data;
               state_d = S_B;
            end
         end
         state_q == S_B: begin
            if (xfer) begin
               b_d     = bus.in_data;
               state_d = S_OP;
            end
         end
         state_q == S_OP: begin
            if (xfer) begin
               s_d     = bus.in_data[1:0];
               cnt_d   = 4'd0;
               state_d = S_EXEC;
`ifdef ALU_SEQ_ACCUM_EN
               chain_d = bus.in_data[7];
`endif
            end
         end
         state_q == S_EXEC: begin
            cnt_d = cnt_q + 4'd1;
            if (exec_done) begin
               res_d   = alu_result;
               vld_d   = 1'b1;
               state_d = S_OUT;
            end
         end
         state_q == S_OUT: begin
            if (accept) begin
               vld_d   = 1'b0;
               ops_d   = ops_q + CNT_ONE;
               state_d = S_A;
`ifdef ALU_SEQ_ACCUM_EN
               // Chained result becomes operand A; next byte is B.
               if (chain_q) begin
                  a_d     = res_q;
                  state_d = S_B;
               end
`endif
            end
         end
         default: begin
            state_d = S_A;
         end
      endcase

      // Abort cancels any load or accept made this cycle.
      if (abort) begin
         state_d = S_A;
         vld_d   = 1'b0;
         a_d     = a_q;
         b_d     = b_q;
         s_d     = s_q;
         res_d   = res_q;
         ops_d   = ops_q;
`ifdef ALU_SEQ_ACCUM_EN
         chain_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_A;
         cnt_q   <= 4'd0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= 2'd0;
         res_q   <= '0;
         vld_q   <= 1'b0;
         ops_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
         ops_q   <= ops_d;
      end
   end

`ifdef ALU_SEQ_ACCUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= 1'b0;
      end else begin
         chain_q <= chain_d;
      end
   end
`endif

   assign bus.in_ready  = in_rdy;
   assign bus.res_data  = res_q;
   assign bus.res_valid = vld_q;
   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign alu_s         = s_q;
   assign busy          = (state_q != S_A);
   assign op_count      = ops_q;

endmodule
